integer_unit_mc: RTL and testbench

- Next-generation warp-wide integer execution unit, between the Operand Collector and the Result Collector.
- Extends the single-cycle integer ALU with:
  - a richer operation set (sub, logic, shifts, compares);
  - an iterative multi-cycle multiplier whose throughput is set by a parameter;
  - explicit FSM-controlled output buffering with full valid/ready backpressure.

---
 rtl/integer_unit_mc_pkg.sv | 46 ++++
 rtl/integer_unit_mc_mul_iter.sv | 51 +++++
 rtl/integer_unit_mc.sv | 169 ++++++++++++++++
 tb/tb_integer_unit_mc.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/integer_unit_mc_pkg.sv
// Shared integer-unit instruction subtypes, FSM states and the legal-subtype check.
package integer_unit_mc_pkg;

   typedef enum logic [4:0] {
      IU_ADD  = 5'd0,
      IU_SUB  = 5'd1,
      IU_AND  = 5'd2,
      IU_OR   = 5'd3,
      IU_XOR  = 5'd4,
      IU_SHL  = 5'd5,
      IU_SHR  = 5'd6,
      IU_SRA  = 5'd7,
      IU_SLT  = 5'd8,
      IU_SLTU = 5'd9,
      IU_TID  = 5'd10,
      IU_LDI  = 5'd11,
      IU_MUL  = 5'd12
   } bgpu_inst_subtype_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      FULL = 2'd2
   } iu_mc_state_e;

   localparam int unsigned IuNumValidSubtypes = 13;

   localparam bgpu_inst_subtype_e BGPU_INT_UNIT_VALID_SUBTYPES
      [IuNumValidSubtypes] = '{
      IU_ADD, IU_SUB, IU_AND, IU_OR, IU_XOR,
      IU_SHL, IU_SHR, IU_SRA, IU_SLT, IU_SLTU,
      IU_TID, IU_LDI, IU_MUL
   };

   function automatic logic iu_valid_subtype(
      input bgpu_inst_subtype_e sub
   );
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < IuNumValidSubtypes; i++) begin
         if (sub == BGPU_INT_UNIT_VALID_SUBTYPES[i]) ok = 1'b1;
      end
      return ok;
   endfunction

endpackage

// File: rtl/integer_unit_mc_mul_iter.sv
// One lane of the iterative multiplier: holds the operands and
// accumulates one MulBitsPerCycle-wide partial product per step.
module integer_mul_iter
   import integer_unit_mc_pkg::*;
#(
   parameter int RegWidth        = 32,
   parameter int MulBitsPerCycle = 4,
   parameter int CntW            = 3
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_load,
   input  logic                i_step,
   input  logic [RegWidth-1:0] i_a,
   input  logic [RegWidth-1:0] i_b,
   input  logic [CntW-1:0]     i_cnt,
   output logic [RegWidth-1:0] o_acc_nxt
);

   localparam int ShW = $clog2(RegWidth);

   logic [RegWidth-1:0]        r_a;
   logic [RegWidth-1:0]        r_b;
   logic [RegWidth-1:0]        r_acc;
   logic [ShW-1:0]             w_sh;
   logic [RegWidth-1:0]        w_b_shr;
   logic [MulBitsPerCycle-1:0] w_chunk;
   logic [RegWidth-1:0]        w_part;

   assign w_sh    = ShW'(i_cnt) * ShW'(MulBitsPerCycle);
   assign w_b_shr = r_b >> w_sh;
   assign w_chunk = w_b_shr[MulBitsPerCycle-1:0];
   assign w_part  = (r_a << w_sh) * RegWidth'(w_chunk);

   assign o_acc_nxt = r_acc + w_part;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_acc <= '0;
      end else if (i_load) begin
         r_a   <= i_a;
         r_b   <= i_b;
         r_acc <= '0;
      end else if (i_step) begin
         r_acc <= o_acc_nxt;
      end
   end

endmodule

// File: rtl/integer_unit_mc.sv
// Warp-wide integer execution unit: single-cycle ALU ops, iterative
// multiplier and a one-entry output buffer with valid/ready backpressure.
module integer_unit_mc
   import integer_unit_mc_pkg::*;
#(
   parameter int  RegWidth        = 32,
   parameter int  WarpWidth       = 4,
   parameter int  OperandsPerInst = 2,
   parameter int  MulBitsPerCycle = 4,
   parameter type iid_t           = logic,
   parameter type reg_idx_t       = logic,
   parameter type warp_data_t     = logic [RegWidth*WarpWidth-1:0]
) (
   input  logic               clk_i,
   input  logic               rst_i,
   output logic               eu_to_opc_ready_o,
   input  logic               opc_to_eu_valid_i,
   input  iid_t               opc_to_eu_tag_i,
   input  bgpu_inst_subtype_e opc_to_eu_inst_sub_i,
   input  reg_idx_t           opc_to_eu_dst_i,
   input  warp_data_t         opc_to_eu_operands_i [OperandsPerInst],
   input  logic               rc_to_eu_ready_i,
   output logic               eu_to_rc_valid_o,
   output iid_t               eu_to_rc_tag_o,
   output reg_idx_t           eu_to_rc_dst_o,
   output warp_data_t         eu_to_rc_data_o,
   output logic               illegal_op_o
);

   localparam int MulCycles = RegWidth / MulBitsPerCycle;
   localparam int CntW      = (MulCycles > 1) ? $clog2(MulCycles) : 1;
   localparam int ShW       = $clog2(RegWidth);

   iu_mc_state_e    r_state;
   iu_mc_state_e    w_state_nxt;
   logic [CntW-1:0] r_cnt;
   iid_t            r_tag;
   reg_idx_t        r_dst;
   warp_data_t      r_data;
   logic            r_illegal;

   logic       w_accept;
   logic       w_is_mul;
   logic       w_valid_sub;
   logic       w_mul_last;
   logic       w_mul_load;
   logic       w_mul_step;
   warp_data_t w_alu;
   warp_data_t w_mul_nxt;

   assign eu_to_opc_ready_o = (r_state == IDLE) |
                              ((r_state == FULL) & rc_to_eu_ready_i);

   assign w_accept    = opc_to_eu_valid_i & eu_to_opc_ready_o;
   assign w_is_mul    = (opc_to_eu_inst_sub_i == IU_MUL);
   assign w_valid_sub = iu_valid_subtype(opc_to_eu_inst_sub_i);
   assign w_mul_step  = (r_state == MUL);
   assign w_mul_last  = w_mul_step & (r_cnt == CntW'(MulCycles - 1));
   assign w_mul_load  = w_accept & w_is_mul;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE, FULL: begin
            if (w_accept) begin
               w_state_nxt = w_is_mul ? MUL : FULL;
            end else if ((r_state == FULL) && rc_to_eu_ready_i) begin
               w_state_nxt = IDLE;
            end
         end
         MUL: begin
            if (w_mul_last) w_state_nxt = FULL;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   for (genvar g = 0; g < WarpWidth; g++) begin : g_lane
      logic [RegWidth-1:0] w_a;
      logic [RegWidth-1:0] w_b;
      logic [RegWidth-1:0] w_res;
      logic [RegWidth-1:0] w_acc_nxt;
      logic [ShW-1:0]      w_sh;

      assign w_a  = opc_to_eu_operands_i[0][g*RegWidth +: RegWidth];
      assign w_b  = opc_to_eu_operands_i[1][g*RegWidth +: RegWidth];
      assign w_sh = w_b[ShW-1:0];

      always_comb begin
         w_res = '0;
         unique case (opc_to_eu_inst_sub_i)
            IU_ADD:  w_res = w_a + w_b;
            IU_SUB:  w_res = w_a - w_b;
            IU_AND:  w_res = w_a & w_b;
            IU_OR:   w_res = w_a | w_b;
            IU_XOR:  w_res = w_a ^ w_b;
            IU_SHL:  w_res = w_a << w_sh;
            IU_SHR:  w_res = w_a >> w_sh;
            IU_SRA:  w_res = $signed(w_a) >>> w_sh;
            IU_SLT:  w_res = RegWidth'($signed(w_a) < $signed(w_b));
            IU_SLTU: w_res = RegWidth'(w_a < w_b);
            IU_TID:  w_res = RegWidth'(g);
            IU_LDI:  w_res = w_a | w_b;
            default: w_res = '0;
         endcase
      end

      assign w_alu[g*RegWidth +: RegWidth]     = w_res;
      assign w_mul_nxt[g*RegWidth +: RegWidth] = w_acc_nxt;

      integer_mul_iter #(
         .RegWidth        (RegWidth),
         .MulBitsPerCycle (MulBitsPerCycle),
         .CntW            (CntW)
      ) u_mul (
         .i_clk     (clk_i),
         .i_rst     (rst_i),
         .i_load    (w_mul_load),
         .i_step    (w_mul_step),
         .i_a       (w_a),
         .i_b       (w_b),
         .i_cnt     (r_cnt),
         .o_acc_nxt (w_acc_nxt)
      );
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_tag     <= '0;
         r_dst     <= '0;
         r_data    <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_illegal <= w_accept & ~w_valid_sub;
         if (w_accept) begin
            r_tag <= opc_to_eu_tag_i;
            r_dst <= opc_to_eu_dst_i;
            if (!w_is_mul) r_data <= w_alu;
         end
         if (w_mul_load) begin
            r_cnt <= '0;
         end else if (w_mul_step) begin
            r_cnt <= w_mul_last ? '0 : r_cnt + 1'b1;
         end
         // final partial product lands straight in the output buffer
         if (w_mul_last) r_data <= w_mul_nxt;
      end
   end

   assign eu_to_rc_valid_o = (r_state == FULL);
   assign eu_to_rc_tag_o   = r_tag;
   assign eu_to_rc_dst_o   = r_dst;
   assign eu_to_rc_data_o  = r_data;
   assign illegal_op_o     = r_illegal;

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (!rst_i && w_accept) begin
         assert (w_valid_sub)
            else $warning("integer_unit_mc: unsupported subtype %0d",
                          opc_to_eu_inst_sub_i);
      end
   end
`endif

endmodule

// File: tb/tb_integer_unit_mc.sv
// Directed self-checking bench for integer_unit_mc (default parameters,
// widened tag/dst types).
module tb_integer_unit_mc;
   import integer_unit_mc_pkg::*;

   logic               clk;
   logic               rst;
   logic               ready_o;
   logic               valid_i;
   logic [3:0]         tag_i;
   bgpu_inst_subtype_e sub_i;
   logic [4:0]         dst_i;
   logic [127:0]       ops [2];
   logic               rc_ready;
   logic               valid_o;
   logic [3:0]         tag_o;
   logic [4:0]         dst_o;
   logic [127:0]       data_o;
   logic               illegal;

   int total = 0;
   int bad   = 0;

   integer_unit_mc #(
      .iid_t     (logic [3:0]),
      .reg_idx_t (logic [4:0])
   ) dut (
      .clk_i                (clk),
      .rst_i                (rst),
      .eu_to_opc_ready_o    (ready_o),
      .opc_to_eu_valid_i    (valid_i),
      .opc_to_eu_tag_i      (tag_i),
      .opc_to_eu_inst_sub_i (sub_i),
      .opc_to_eu_dst_i      (dst_i),
      .opc_to_eu_operands_i (ops),
      .rc_to_eu_ready_i     (rc_ready),
      .eu_to_rc_valid_o     (valid_o),
      .eu_to_rc_tag_o       (tag_o),
      .eu_to_rc_dst_o       (dst_o),
      .eu_to_rc_data_o      (data_o),
      .illegal_op_o         (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      total++;
      assert (obs === exp)
         else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   function automatic logic [127:0] rep(input logic [31:0] v);
      return {4{v}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drive one replicated-lane instruction, clock it in, drop valid
   task automatic do_op(input bgpu_inst_subtype_e s,
                        input logic [31:0] a, input logic [31:0] b);
      sub_i   = s;
      ops[0]  = rep(a);
      ops[1]  = rep(b);
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
   endtask

   initial begin
      bit stale;
      rst      = 1'b1;
      valid_i  = 1'b0;
      tag_i    = 4'h0;
      dst_i    = 5'd0;
      sub_i    = IU_ADD;
      ops[0]   = '0;
      ops[1]   = '0;
      rc_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_valid", valid_o, 0);
      chk("rst_ready", ready_o, 1);
      chk("rst_data", data_o, 0);
      chk("rst_tag", tag_o, 0);
      chk("rst_illegal", illegal, 0);

      // ADD back-to-back
      valid_i = 1'b1;
      sub_i   = IU_ADD;
      tag_i   = 4'h3;
      ops[0]  = rep(32'd5);
      ops[1]  = rep(32'd3);
      chk("add_ready0", ready_o, 1);
      tick();
      chk("add_valid1", valid_o, 1);
      chk("add_data1", data_o, rep(32'd8));
      chk("add_tag1", tag_o, 4'h3);
      ops[0] = rep(32'hFFFF_FFFF);
      ops[1] = rep(32'd1);
      tag_i  = 4'h4;
      chk("add_ready1", ready_o, 1);
      tick();
      valid_i = 1'b0;
      chk("add_valid2", valid_o, 1);
      chk("add_data2", data_o, rep(32'd0));
      chk("add_tag2", tag_o, 4'h4);
      tick();
      chk("add_idle", valid_o, 0);

      // SUB under backpressure
      rc_ready = 1'b0;
      do_op(IU_SUB, 32'd10, 32'd3);
      for (int k = 0; k < 4; k++) begin
         chk("bp_valid", valid_o, 1);
         chk("bp_data", data_o, rep(32'd7));
         chk("bp_ready", ready_o, 0);
         tick();
      end
      rc_ready = 1'b1;
      #1;
      chk("bp_ready_rise", ready_o, 1);
      tick();
      chk("bp_idle_valid", valid_o, 0);
      chk("bp_idle_ready", ready_o, 1);

      // MUL, distinct per-lane operands
      tag_i   = 4'hA;
      dst_i   = 5'd17;
      sub_i   = IU_MUL;
      ops[0]  = {32'h0001_0000, 32'd3, 32'hFFFF_FFFF, 32'd7};
      ops[1]  = {32'h0001_0000, 32'd5, 32'd2, 32'd6};
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      tag_i   = 4'h0;
      dst_i   = 5'd0;
      for (int k = 0; k < 8; k++) begin
         chk("mul_busy_ready", ready_o, 0);
         chk("mul_busy_valid", valid_o, 0);
         tick();
      end
      chk("mul_valid", valid_o, 1);
      chk("mul_data", data_o,
          {32'd0, 32'd15, 32'hFFFF_FFFE, 32'd42});
      chk("mul_tag", tag_o, 4'hA);
      chk("mul_dst", dst_o, 5'd17);
      tick();
      chk("mul_idle", valid_o, 0);

      // shifts and compares, back-to-back
      do_op(IU_SRA, 32'h8000_0000, 32'd4);
      chk("sra", data_o, rep(32'hF800_0000));
      do_op(IU_SHR, 32'h8000_0000, 32'd4);
      chk("shr", data_o, rep(32'h0800_0000));
      do_op(IU_SHL, 32'd1, 32'd33);
      chk("shl_mask", data_o, rep(32'd2));
      do_op(IU_SLT, 32'hFFFF_FFFF, 32'd1);
      chk("slt", data_o, rep(32'd1));
      do_op(IU_SLTU, 32'hFFFF_FFFF, 32'd1);
      chk("sltu", data_o, rep(32'd0));
      do_op(IU_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF);
      chk("xor", data_o, rep(32'hFF00_EDCB));
      tick();
      chk("ops_idle", valid_o, 0);

      // reset in the third MUL cycle
      do_op(IU_MUL, 32'd9, 32'd9);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("rstmul_valid", valid_o, 0);
      chk("rstmul_ready", ready_o, 1);
      rst   = 1'b0;
      stale = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (valid_o !== 1'b0) stale = 1'b1;
         tick();
      end
      chk("rstmul_no_stale", stale, 0);

      // TID then an unsupported subtype
      do_op(IU_TID, 32'd0, 32'd0);
      chk("tid", data_o, {32'd3, 32'd2, 32'd1, 32'd0});
      chk("tid_illegal", illegal, 0);
      do_op(bgpu_inst_subtype_e'(5'd31), 32'h1234_5678, 32'd1);
      chk("ill_data", data_o, 0);
      chk("ill_valid", valid_o, 1);
      chk("ill_pulse", illegal, 1);
      tick();
      chk("ill_pulse_end", illegal, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
